// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one registered 4-bit output among four valid/ready requesters.
// Optional per-requester saturating grant counters: define RR_MUX_ARB_GRANT_CNT_EN.
module rr_mux_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_valid,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] req_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  output logic [1:0] out_sel,
  input  logic       out_ready
`ifdef RR_MUX_ARB_GRANT_CNT_EN
  ,
  output logic [31:0] grant_cnt
`endif
);

  logic [1:0] r_ptr;
  logic       r_out_valid;
  logic [3:0] r_out_data;
  logic [1:0] r_out_sel;

  logic       w_load_en;
  logic       w_any;
  logic [1:0] w_gnt;
  logic [3:0] w_mux;
  logic [1:0] w_cand [4];

  assign w_load_en = !r_out_valid || out_ready;
  assign w_any     = |req_valid;

  // w_cand[k] is the requester index examined k-th in the search order
  for (genvar gi = 0; gi < 4; gi++) begin : g_cand
    assign w_cand[gi] = r_ptr + 2'(gi);
  end

  // Walk from lowest to highest priority so the earliest hit wins
  always_comb begin
    w_gnt = r_ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req_valid[w_cand[k]]) begin
        w_gnt = w_cand[k];
      end
    end
  end

  always_comb begin
    case (w_gnt)
      2'd0: w_mux = d0;
      2'd1: w_mux = d1;
      2'd2: w_mux = d2;
      2'd3: w_mux = d3;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_ready
    assign req_ready[gi] = rst_n && w_load_en && w_any && (w_gnt == 2'(gi));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= 4'h0;
      r_out_sel   <= 2'd0;
      r_ptr       <= 2'd0;
    end else if (w_load_en) begin
      if (w_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_mux;
        r_out_sel   <= w_gnt;
        r_ptr       <= w_gnt + 2'd1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

`ifdef RR_MUX_ARB_GRANT_CNT_EN
  logic [7:0] r_cnt [4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_cnt[k] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (req_valid[k] && req_ready[k] && (r_cnt[k] != 8'hFF)) begin
          r_cnt[k] <= r_cnt[k] + 8'h01;
        end
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt_out
    assign grant_cnt[8*gi +: 8] = r_cnt[gi];
  end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter; one line printed per checked transaction.
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_valid;
  logic [3:0] d0, d1, d2, d3;
  logic [3:0] req_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_sel;
  logic       out_ready;
`ifdef RR_MUX_ARB_GRANT_CNT_EN
  logic [31:0] grant_cnt;
`endif

  int checks;
  int errors;

  rr_mux_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
`ifdef RR_MUX_ARB_GRANT_CNT_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so registered outputs can be sampled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b0000; out_ready = 1'b0;
    d0 = 4'h0; d1 = 4'h0; d2 = 4'h0; d3 = 4'h0;
    for (int c = 0; c < 2; c++) begin
      if (c == 1) begin
        req_valid = 4'b1111; out_ready = 1'b1;
        #1;
      end
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++; $display("FAIL reset_ready cyc%0d got %b want 0000", c, req_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 4'h0 || out_sel !== 2'd0) begin
        errors++;
        $display("FAIL reset_out cyc%0d got v=%b d=%h s=%0d want v=0 d=0 s=0", c, out_valid, out_data, out_sel);
      end else $display("reset cyc%0d v=%b d=%h s=%0d", c, out_valid, out_data, out_sel);
    end
    req_valid = 4'b0000; out_ready = 1'b0;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    req_valid = 4'b0100; d2 = 4'hA; out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL single_ready got %b want 0100", req_ready);
    end
    tick();
    req_valid = 4'b0000;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'hA || out_sel !== 2'd2) begin
      errors++;
      $display("FAIL single_out got v=%b d=%h s=%0d want v=1 d=a s=2", out_valid, out_data, out_sel);
    end else $display("single v=%b d=%h s=%0d", out_valid, out_data, out_sel);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain got v=%b want 0", out_valid);
    end
  endtask

  // Pointer is 3 here after the single-requester grant of 2
  task automatic test_wrap_skip();
    d1 = 4'h5; d3 = 4'h9; out_ready = 1'b1;
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++; $display("FAIL wrap_ready got %b want 0010", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 4'h5) begin
      errors++;
      $display("FAIL wrap_out got v=%b d=%h s=%0d want v=1 d=5 s=1", out_valid, out_data, out_sel);
    end else $display("wrap v=%b d=%h s=%0d", out_valid, out_data, out_sel);
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++; $display("FAIL skip_ready got %b want 1000", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== 4'h9) begin
      errors++;
      $display("FAIL skip_out got v=%b d=%h s=%0d want v=1 d=9 s=3", out_valid, out_data, out_sel);
    end else $display("skip v=%b d=%h s=%0d", out_valid, out_data, out_sel);
    req_valid = 4'b0000;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL skip_drain got v=%b want 0", out_valid);
    end
  endtask

  // Pointer is 0 here; expect strict rotation with no empty cycles
  task automatic test_all_four();
    logic [1:0] exp_sel [5];
    logic [3:0] exp_dat [5];
    logic [3:0] exp_rdy [5];
    exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_dat = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    exp_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    d0 = 4'h1; d1 = 4'h2; d2 = 4'h3; d3 = 4'h4;
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (req_ready !== exp_rdy[i]) begin
        errors++; $display("FAIL all4_ready[%0d] got %b want %b", i, req_ready, exp_rdy[i]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== exp_sel[i] || out_data !== exp_dat[i]) begin
        errors++;
        $display("FAIL all4_out[%0d] got v=%b d=%h s=%0d want v=1 d=%h s=%0d",
                 i, out_valid, out_data, out_sel, exp_dat[i], exp_sel[i]);
      end else $display("all4[%0d] v=%b d=%h s=%0d", i, out_valid, out_data, out_sel);
    end
  endtask

  // Pointer is 1: load requester 1, then stall three cycles
  task automatic test_backpressure();
    tick();
    checks++;
    if (out_sel !== 2'd1 || out_data !== 4'h2) begin
      errors++; $display("FAIL bp_setup got d=%h s=%0d want d=2 s=1", out_data, out_sel);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++; $display("FAIL bp_ready[%0d] got %b want 0000", i, req_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_sel !== 2'd1 || out_data !== 4'h2) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h s=%0d want v=1 d=2 s=1", i, out_valid, out_data, out_sel);
      end else $display("bp_hold[%0d] v=%b d=%h s=%0d", i, out_valid, out_data, out_sel);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++; $display("FAIL bp_release_ready got %b want 0100", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sel !== 2'd2 || out_data !== 4'h3) begin
      errors++;
      $display("FAIL bp_release_out got v=%b d=%h s=%0d want v=1 d=3 s=2", out_valid, out_data, out_sel);
    end else $display("bp_release v=%b d=%h s=%0d", out_valid, out_data, out_sel);
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++; $display("FAIL rst_stall_ready got %b want 0000", req_ready);
    end
    tick();
    rst_n = 1'b1;
    req_valid = 4'b0000;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_sel !== 2'd0) begin
      errors++;
      $display("FAIL rst_stall_out got v=%b d=%h s=%0d want v=0 d=0 s=0", out_valid, out_data, out_sel);
    end else $display("rst_stall v=%b d=%h s=%0d", out_valid, out_data, out_sel);
`ifdef RR_MUX_ARB_GRANT_CNT_EN
    checks++;
    if (grant_cnt !== 32'h0) begin
      errors++; $display("FAIL rst_cnt got %h want 00000000", grant_cnt);
    end
`endif
    // Pointer must be back at 0: all four requesting grants requester 0
    req_valid = 4'b1111; out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++; $display("FAIL rst_ptr got %b want 0001", req_ready);
    end
    req_valid = 4'b0000;
  endtask

`ifdef RR_MUX_ARB_GRANT_CNT_EN
  task automatic test_grant_cnt();
    // Fresh reset so counts start at zero
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'b0001; out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 9) begin
        checks++;
        if (grant_cnt !== 32'h0000_000A) begin
          errors++; $display("FAIL cnt_mid got %h want 0000000a", grant_cnt);
        end else $display("cnt_mid %h", grant_cnt);
      end
    end
    checks++;
    if (grant_cnt !== 32'h0000_00FF) begin
      errors++; $display("FAIL cnt_sat got %h want 000000ff", grant_cnt);
    end else $display("cnt_sat %h", grant_cnt);
    req_valid = 4'b0000;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_wrap_skip();
    test_all_four();
    test_backpressure();
    test_reset_mid_stall();
`ifdef RR_MUX_ARB_GRANT_CNT_EN
    test_grant_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
